// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads instruction memory and queues {pc, inst} for decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target enters a trap state).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data_in,
  output logic        imem_read_write,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready,
  output logic        misalign_trap
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  state_t             state_reg;
  logic [31:0]        fetch_pc_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic               out_valid_reg;
  logic [31:0]        out_pc_reg;
  logic [31:0]        out_inst_reg;

  logic [31:0]        pc_mem   [DEPTH];
  logic [31:0]        inst_mem [DEPTH];

  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   head_next;
  logic [CNT_W-1:0]   remain_next;
  logic [CNT_W-1:0]   count_next;
  logic [31:0]        head_pc_next;
  logic [31:0]        head_inst_next;
  logic [31:0]        redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic               misalign_trap_reg;
  logic               redirect_misaligned;

  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign misalign_trap       = misalign_trap_reg;
`else
  logic               unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misalign_trap        = 1'b0;
`endif

  assign pop  = out_valid_reg && out_ready;
  assign push = (state_reg == ST_RUN) && !redirect_valid && ((count_reg < DEPTH_CNT) || pop);

  assign head_next   = head_reg + PTR_W'(pop);
  assign remain_next = count_reg - CNT_W'(pop);
  assign count_next  = remain_next + CNT_W'(push);

  // The output registers hold the post-edge head; if the FIFO drains to the
  // entry being written this cycle, forward the fetch data straight through.
  always_comb begin
    head_pc_next   = pc_mem[head_next];
    head_inst_next = inst_mem[head_next];
    if (push && (remain_next == '0)) begin
      head_pc_next   = fetch_pc_reg;
      head_inst_next = imem_data_out;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[tail_reg]   <= fetch_pc_reg;
      inst_mem[tail_reg] <= imem_data_out;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_BOOT;
      fetch_pc_reg      <= RESET_PC;
      count_reg         <= '0;
      head_reg          <= '0;
      tail_reg          <= '0;
      out_valid_reg     <= 1'b0;
      out_pc_reg        <= '0;
      out_inst_reg      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap_reg <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Redirect wins over everything: flush, drop any pop, restart at target.
      count_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      out_valid_reg <= 1'b0;
      fetch_pc_reg  <= redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_misaligned) begin
        state_reg         <= ST_TRAP;
        misalign_trap_reg <= 1'b1;
      end else begin
        state_reg         <= ST_RUN;
        misalign_trap_reg <= 1'b0;
      end
`else
      state_reg     <= ST_RUN;
`endif
    end else begin
      if (state_reg == ST_BOOT) begin
        state_reg <= ST_RUN;
      end
      count_reg     <= count_next;
      head_reg      <= head_next;
      out_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        out_pc_reg   <= head_pc_next;
        out_inst_reg <= head_inst_next;
      end
      if (push) begin
        tail_reg     <= tail_reg + PTR_W'(1);
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
    end
  end

  assign imem_address    = fetch_pc_reg;
  assign imem_data_in    = 32'h0;
  assign imem_read_write = 1'b0;
  assign out_valid       = out_valid_reg;
  assign out_pc          = out_pc_reg;
  assign out_inst        = out_inst_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, random traffic against a queue model, async reset.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_address;
  logic [31:0] imem_data_in;
  logic        imem_read_write;
  logic [31:0] imem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        misalign_trap;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_address    (imem_address),
    .imem_data_in    (imem_data_in),
    .imem_read_write (imem_read_write),
    .imem_data_out   (imem_data_out),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_ready       (out_ready),
    .misalign_trap   (misalign_trap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: two preloaded program words, a hash of the address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0100_0000)      return 32'h0050_0093;
    else if (a == 32'h0100_0004) return 32'h0010_8113;
    else                         return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_data_out = mem_word(imem_address);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_trap;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = RESET_PC;
    m_boot = 1'b1;
    m_trap = 1'b0;
  endtask

  // One clock edge of the fetch behaviour, in queue terms.
  task automatic model_edge(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit do_pop;
    bit do_push;
    do_pop = (q.size() != 0) && rdy;
    if (redir) begin
      q.delete();
      if (TRAP_EN) begin
        m_pc   = rpc;
        m_trap = (rpc[1:0] != 2'b00);
      end else begin
        m_pc = {rpc[31:2], 2'b00};
      end
    end else begin
      do_push = !m_boot && !m_trap && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 1'b0;
  endtask

  task automatic check_model();
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("imem_address", imem_address, m_pc);
    chk("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    chk("imem_ctrl", {imem_data_in[30:0], imem_read_write}, 32'h0);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_inst", out_inst, q[0].inst);
    end
  endtask

  // Called at a falling edge; applies inputs across the next rising edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_edge(redir, rpc, rdy);
    @(posedge clock);
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_trap", 32'(misalign_trap), 32'h0);
    chk("rst_addr", imem_address, RESET_PC);
    model_reset();
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    bit          ci;
    logic [31:0] einst;
    logic [31:0] eaddr;
    bit          etrap;
  } vec_t;

  function automatic vec_t mk(bit rst, bit redir, logic [31:0] rpc, bit rdy, bit ev,
                              logic [31:0] epc, bit ci, logic [31:0] einst,
                              logic [31:0] eaddr, bit etrap);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
    v.epc = epc; v.ci = ci; v.einst = einst; v.eaddr = eaddr; v.etrap = etrap;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    logic [31:0] rpc;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Boot and stream the two preloaded words.
    vecs[0]  = mk(0, 0, 0, 1, 0, 0,            0, 0,            32'h0100_0000, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 32'h0100_0000, 1, 32'h0050_0093, 32'h0100_0004, 0);
    vecs[2]  = mk(0, 0, 0, 1, 1, 32'h0100_0004, 1, 32'h0010_8113, 32'h0100_0008, 0);
    // Backpressure: FIFO fills, fetch address holds, then drains in order.
    vecs[3]  = mk(1, 0, 0, 0, 0, 0,            0, 0,            32'h0100_0000, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 0,            0, 0,            32'h0100_0000, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 32'h0100_0000, 1, 32'h0050_0093, 32'h0100_0004, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0,            32'h0100_0008, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0,            32'h0100_0008, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0,            32'h0100_0008, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0,            32'h0100_0008, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0,            32'h0100_0008, 0);
    vecs[11] = mk(0, 0, 0, 1, 1, 32'h0100_0004, 1, 32'h0010_8113, 32'h0100_000C, 0);
    vecs[12] = mk(0, 0, 0, 1, 1, 32'h0100_0008, 0, 0,            32'h0100_0010, 0);
    vecs[13] = mk(0, 0, 0, 1, 1, 32'h0100_000C, 0, 0,            32'h0100_0014, 0);
    // Redirect while full.
    vecs[14] = mk(0, 1, 32'h0100_0040, 1, 0, 0, 0, 0, 32'h0100_0040, 0);
    vecs[15] = mk(0, 0, 0, 1, 1, 32'h0100_0040, 0, 0, 32'h0100_0044, 0);
    vecs[16] = mk(0, 0, 0, 1, 1, 32'h0100_0044, 0, 0, 32'h0100_0048, 0);
    // Misaligned redirect, then aligned recovery.
    vecs[17] = mk(0, 1, 32'h0100_0042, 1, 0, 0, 0, 0,
                  TRAP_EN ? 32'h0100_0042 : 32'h0100_0040, TRAP_EN);
    vecs[18] = mk(0, 0, 0, 1, !TRAP_EN, 32'h0100_0040, 0, 0,
                  TRAP_EN ? 32'h0100_0042 : 32'h0100_0044, TRAP_EN);
    vecs[19] = mk(0, 1, 32'h0100_0000, 1, 0, 0, 0, 0, 32'h0100_0000, 0);
    vecs[20] = mk(0, 0, 0, 1, 1, 32'h0100_0000, 1, 32'h0050_0093, 32'h0100_0004, 0);

    do_reset();

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].rst) do_reset();
      else step(vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      chk("tbl_valid", 32'(out_valid), 32'(vecs[i].ev));
      chk("tbl_addr", imem_address, vecs[i].eaddr);
      chk("tbl_trap", 32'(misalign_trap), 32'(vecs[i].etrap));
      if (vecs[i].ev) chk("tbl_pc", out_pc, vecs[i].epc);
      if (vecs[i].ci) chk("tbl_inst", out_inst, vecs[i].einst);
      $display("vec %0d: valid=%0b pc=%h inst=%h addr=%h trap=%0b",
               i, out_valid, out_pc, out_inst, imem_address, misalign_trap);
    end

    // Random traffic: backpressure, redirects (some misaligned), occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rpc = 32'h0100_0000 + (32'($urandom_range(0, 63)) << 2);
        if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) != 0);
      end
    end

    // Asynchronous reset in the middle of a cycle with the FIFO full.
    step(1'b1, 32'h0100_0080, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_pc", out_pc, 32'h0);
    chk("async_addr", imem_address, RESET_PC);
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    chk("reboot_idle", 32'(out_valid), 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("reboot_valid", 32'(out_valid), 32'h1);
    chk("reboot_pc", out_pc, RESET_PC);
    $display("async reset: valid=%0b pc=%h addr=%h", out_valid, out_pc, imem_address);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch initiator for the single-cycle/pipelined RV32 core. It owns the fetch PC and drives the instruction memory read port. It captures the memory's combinational read data into a small in-order instruction FIFO and presents {pc, instruction} to decode through a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch at the new target.

## Interface
Parameters:
- RESET_PC, 32'h01000000, first fetch address after reset (program base)
- DEPTH, 2, FIFO entries; power of two, ≥2

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_address  out  32  byte address to instruction memory; equals fetch_pc
- imem_data_in  out  32  memory write data; constant 0
- imem_read_write  out  1  memory direction; constant 0 (read)
- imem_data_out  in  32  combinational little-endian word at imem_address
- redirect_valid  in  1  take redirect this cycle
- redirect_pc  in  32  redirect target
- out_valid  out  1  FIFO head holds a valid instruction
- out_pc  out  32  PC of FIFO head
- out_inst  out  32  instruction word of FIFO head
- out_ready  in  1  decode accepts the head this cycle
- misalign_trap  out  1  misaligned redirect target detected (see Configuration)

## Operation
- State machine: BOOT → RUN; TRAP reachable only with the macro.
  - BOOT: entered on reset; lasts exactly one cycle; no push; moves to RUN.
  - RUN: fetch every cycle the FIFO can accept.
- push = (state==RUN) && !redirect_valid && (count<DEPTH || pop); the push entry is {fetch_pc, imem_data_out}; fetch_pc += 4 on push, wrapping modulo 2^32.
- pop = out_valid && out_ready; head advances.
- A push and a pop in the same cycle with count==DEPTH is legal; count is unchanged.
- count is $clog2(DEPTH)+1 bits wide; head and tail pointers wrap modulo DEPTH.
- out_valid = (count!=0); out_pc and out_inst are read from the head entry. They are undefined but stable-registered when count==0.
- redirect_valid has the highest priority:
  - count←0 and pointers←0; any pop in the same cycle is discarded.
  - fetch_pc←redirect_pc; no push that cycle.
- Handshake: while out_valid && !out_ready, out_pc and out_inst hold stable. Once raised, out_valid drops only on a pop that empties the FIFO or on a redirect.

## Timing
- Reset (async, any time, including mid-operation):
  - state=BOOT, fetch_pc=RESET_PC, count=0, pointers=0.
  - out_valid=0, out_pc=0, out_inst=0, misalign_trap=0.
  - imem_address=RESET_PC.
- First push occurs at the 2nd rising edge after reset_n deasserts. out_valid=1 after that edge, with out_pc=RESET_PC.
- Steady state with out_ready=1: one instruction per cycle, with one cycle of latency from address to out_valid.
- Redirect at edge N: out_valid=0 after N; target pushed at N+1; out_pc=target after N+1.
- FIFO full and out_ready=0: fetch_pc and imem_address hold.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 flushes the FIFO, loads fetch_pc, and enters TRAP.
  - In TRAP: no pushes, and misalign_trap=1 (registered).
  - Exit to RUN only on an aligned redirect (clears misalign_trap) or on reset.
  - A misaligned redirect while in TRAP stays in TRAP.
- FETCH_MISALIGN_TRAP_EN undefined:
  - TRAP does not exist and misalign_trap is tied 0.
  - fetch_pc loads {redirect_pc[31:2], 2'b00}.

## Test plan
- Reset release, memory preloaded with words 0x00500093, 0x00108113 at 0x01000000, out_ready=1 → out_valid rises at 2nd edge; pairs (0x01000000, 0x00500093), then (0x01000004, 0x00108113) on consecutive cycles.
- out_ready=0 for 5 cycles after first valid → FIFO fills to DEPTH; imem_address holds at 0x01000008; head stays (0x01000000, …); on release, PCs 0x01000000/04/08 appear in order with no gaps or duplicates.
- redirect_valid with redirect_pc=0x01000040 while FIFO full and out_ready=1 → out_valid=0 next cycle; next out_pc=0x01000040; no stale PC is ever delivered.
- Async reset asserted mid-cycle with count=2 → out_valid=0 immediately; restart from RESET_PC with the BOOT cycle repeated.
- redirect_pc=0x01000042: with the macro, misalign_trap=1, out_valid stays 0, and an aligned redirect to 0x01000000 clears the trap and resumes fetch; without the macro, fetch resumes at 0x01000040.
